// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single-port data SRAM between the core LSU
// (master 0) and the debug/program-load path (master 1).
// The arbitration is round-robin and the response pipeline is one entry deep,
// so back-to-back accesses run at one transfer per cycle.
// Optional feature macro: DMEM_ARB_PERF_EN adds saturating per-master stall
// counters (perf_m0_stall_o / perf_m1_stall_o) with a synchronous clear (perf_clr_i).
//
// Handshake: a master raises req with its command and keeps req and the command
// stable until gnt is seen high in the same cycle. gnt high with req high means
// the SRAM accepted the access on that clock edge. rvalid (plus rdata) goes
// high for exactly one cycle, one cycle after gnt, for reads and for writes.
// rvalid has no back-pressure.
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 14
) (
    input  logic                      clk,
    input  logic                      rst_ni,
    input  logic                      m0_req_i,
    output logic                      m0_gnt_o,
    output logic                      m0_rvalid_o,
    input  logic                      m0_we_i,
    input  logic [DATA_WIDTH/8-1:0]   m0_be_i,
    input  logic [ADDR_WIDTH-1:0]     m0_addr_i,
    input  logic [DATA_WIDTH-1:0]     m0_wdata_i,
    output logic [DATA_WIDTH-1:0]     m0_rdata_o,
    input  logic                      m1_req_i,
    output logic                      m1_gnt_o,
    output logic                      m1_rvalid_o,
    input  logic                      m1_we_i,
    input  logic [DATA_WIDTH/8-1:0]   m1_be_i,
    input  logic [ADDR_WIDTH-1:0]     m1_addr_i,
    input  logic [DATA_WIDTH-1:0]     m1_wdata_i,
    output logic [DATA_WIDTH-1:0]     m1_rdata_o,
`ifdef DMEM_ARB_PERF_EN
    input  logic                      perf_clr_i,
    output logic [31:0]               perf_m0_stall_o,
    output logic [31:0]               perf_m1_stall_o,
`endif
    input  logic                      mem_ready_i,
    output logic                      mem_en_o,
    output logic                      mem_we_o,
    output logic [DATA_WIDTH/8-1:0]   mem_be_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

    // last_q holds the most recent winner. Its reset value is 1 so that master 0 wins the first tie.
    logic last_q;
    logic rsp_valid_q;
    logic rsp_owner_q;
    logic accept;
    logic winner;

    // The byte-offset bits and the bits above the SRAM range are ignored on purpose.
    // Range checking is done upstream.
    logic unused_addr;
    assign unused_addr = ^{m0_addr_i, m1_addr_i};

    // Pick the winner: a lone requester wins, and on a tie the master that did not win last time wins.
    always_comb begin
        winner = 1'b0;
        if (m0_req_i && m1_req_i) begin
            winner = ~last_q;
        end else if (m1_req_i) begin
            winner = 1'b1;
        end
        accept = mem_ready_i & (m0_req_i | m1_req_i);
    end

    // Send the winner's command to the SRAM. Write enable is held low when nothing is accepted.
    always_comb begin
        mem_en_o    = accept;
        mem_we_o    = accept & (winner ? m1_we_i : m0_we_i);
        mem_be_o    = winner ? m1_be_i : m0_be_i;
        mem_addr_o  = winner ? m1_addr_i[MEM_ADDR_WIDTH+1:2] : m0_addr_i[MEM_ADDR_WIDTH+1:2];
        mem_wdata_o = winner ? m1_wdata_i : m0_wdata_i;
        m0_gnt_o    = accept & ~winner;
        m1_gnt_o    = accept & winner;
    end

    // Record the round-robin pointer and the one-entry response slot.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= 1'b0;
        end else if (accept) begin
            last_q      <= winner;
            rsp_valid_q <= 1'b1;
            rsp_owner_q <= winner;
        end else begin
            rsp_valid_q <= 1'b0;
        end
    end

    // Send the SRAM read data to the owner of the response in flight. The other master sees zero.
    always_comb begin
        m0_rvalid_o = rsp_valid_q & ~rsp_owner_q;
        m1_rvalid_o = rsp_valid_q & rsp_owner_q;
        m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
        m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;
    end

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] stall0_q;
    logic [31:0] stall1_q;

    // Count the cycles in which each master is requesting but not granted.
    // The count saturates. A clear wins over a simultaneous increment.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            stall0_q <= '0;
            stall1_q <= '0;
        end else if (perf_clr_i) begin
            stall0_q <= '0;
            stall1_q <= '0;
        end else begin
            if (m0_req_i && !m0_gnt_o && (stall0_q != 32'hFFFF_FFFF)) begin
                stall0_q <= stall0_q + 32'd1;
            end
            if (m1_req_i && !m1_gnt_o && (stall1_q != 32'hFFFF_FFFF)) begin
                stall1_q <= stall1_q + 32'd1;
            end
        end
    end

    assign perf_m0_stall_o = stall0_q;
    assign perf_m1_stall_o = stall1_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed and random stimulus for dmem_port_arbiter.
// The reference model is a grant history plus a queue of responses in flight.
// When DMEM_ARB_PERF_EN is defined, the stall counters are also modelled.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [3:0]  m0_be;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [3:0]  m1_be;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        mem_ready, mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic        perf_clr;
    logic [31:0] perf_m0_stall, perf_m1_stall;
    logic [31:0] exp_stall0, exp_stall1;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_q[$];        // owner of each response in flight
    int grant_hist[$];   // every winner since reset, oldest first
    bit last_acc;
    int last_win;

    // Clock
    always #5 clk = ~clk;

    dmem_port_arbiter dut (
        .clk         (clk),
        .rst_ni      (rst_ni),
        .m0_req_i    (m0_req),
        .m0_gnt_o    (m0_gnt),
        .m0_rvalid_o (m0_rvalid),
        .m0_we_i     (m0_we),
        .m0_be_i     (m0_be),
        .m0_addr_i   (m0_addr),
        .m0_wdata_i  (m0_wdata),
        .m0_rdata_o  (m0_rdata),
        .m1_req_i    (m1_req),
        .m1_gnt_o    (m1_gnt),
        .m1_rvalid_o (m1_rvalid),
        .m1_we_i     (m1_we),
        .m1_be_i     (m1_be),
        .m1_addr_i   (m1_addr),
        .m1_wdata_i  (m1_wdata),
        .m1_rdata_o  (m1_rdata),
`ifdef DMEM_ARB_PERF_EN
        .perf_clr_i      (perf_clr),
        .perf_m0_stall_o (perf_m0_stall),
        .perf_m1_stall_o (perf_m1_stall),
`endif
        .mem_ready_i (mem_ready),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_be_o    (mem_be),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin from the grant history: on a tie, the master that did not win last wins.
    // With an empty history, master 0 wins.
    function automatic int pick_winner();
        if (m0_req && m1_req) begin
            if (grant_hist.size() == 0) return 0;
            return (grant_hist[grant_hist.size()-1] == 0) ? 1 : 0;
        end
        return m1_req ? 1 : 0;
    endfunction

    // One clock cycle: check at the negative edge, then update the model at the positive edge.
    task automatic do_cycle(input logic [31:0] rd);
        bit          acc;
        int          win;
        int          own;
        logic [31:0] w_addr;
        mem_rdata = rd;
        @(negedge clk);
        acc = mem_ready && (m0_req || m1_req);
        win = pick_winner();
        chk("gnt0", {31'b0, m0_gnt}, {31'b0, acc && win == 0});
        chk("gnt1", {31'b0, m1_gnt}, {31'b0, acc && win == 1});
        chk("mem_en", {31'b0, mem_en}, {31'b0, acc});
        if (acc) begin
            w_addr = (win == 1) ? m1_addr : m0_addr;
            chk("mem_we", {31'b0, mem_we}, {31'b0, (win == 1) ? m1_we : m0_we});
            chk("mem_be", {28'b0, mem_be}, {28'b0, (win == 1) ? m1_be : m0_be});
            chk("mem_addr", {18'b0, mem_addr}, (w_addr >> 2) & 32'h3FFF);
            chk("mem_wdata", mem_wdata, (win == 1) ? m1_wdata : m0_wdata);
        end else begin
            chk("mem_we_idle", {31'b0, mem_we}, 32'd0);
        end
        own = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        chk("rvalid0", {31'b0, m0_rvalid}, {31'b0, own == 0});
        chk("rvalid1", {31'b0, m1_rvalid}, {31'b0, own == 1});
        chk("rdata0", m0_rdata, (own == 0) ? rd : 32'd0);
        chk("rdata1", m1_rdata, (own == 1) ? rd : 32'd0);
`ifdef DMEM_ARB_PERF_EN
        chk("stall0", perf_m0_stall, exp_stall0);
        chk("stall1", perf_m1_stall, exp_stall1);
`endif
        @(posedge clk);
        if (acc) begin
            exp_q.push_back(win);
            grant_hist.push_back(win);
        end
`ifdef DMEM_ARB_PERF_EN
        if (perf_clr) begin
            exp_stall0 = 0;
            exp_stall1 = 0;
        end else begin
            if (m0_req && !(acc && win == 0) && exp_stall0 != 32'hFFFF_FFFF) exp_stall0++;
            if (m1_req && !(acc && win == 1) && exp_stall1 != 32'hFFFF_FFFF) exp_stall1++;
        end
`endif
        last_acc = acc;
        last_win = win;
        #1;
    endtask

    // Hold reset for n cycles and check the outputs while reset is low.
    // Reset is asserted #1 after a positive edge.
    task automatic reset_for(input int n);
        rst_ni = 1'b0;
        m0_req = 1'b0;
        m1_req = 1'b0;
        exp_q.delete();
        grant_hist.delete();
        last_acc = 1'b0;
`ifdef DMEM_ARB_PERF_EN
        exp_stall0 = 0;
        exp_stall1 = 0;
`endif
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rst_rvalid0", {31'b0, m0_rvalid}, 32'd0);
            chk("rst_rvalid1", {31'b0, m1_rvalid}, 32'd0);
            chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
            chk("rst_rdata0", m0_rdata, 32'd0);
            chk("rst_rdata1", m1_rdata, 32'd0);
        end
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Driver for master 0's request fields.
    task automatic set_m0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata);
        m0_req = req; m0_we = we; m0_addr = addr; m0_be = be; m0_wdata = wdata;
    endtask

    // Driver for master 1's request fields.
    task automatic set_m1(input logic req, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata);
        m1_req = req; m1_we = we; m1_addr = addr; m1_be = be; m1_wdata = wdata;
    endtask

    initial begin
        rst_ni    = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'd0;
        set_m0(1'b0, 1'b0, 32'd0, 4'hF, 32'd0);
        set_m1(1'b0, 1'b0, 32'd0, 4'hF, 32'd0);
`ifdef DMEM_ARB_PERF_EN
        perf_clr = 1'b0;
`endif
        #2;
        reset_for(3);

        // Single master read.
        set_m0(1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'd0);
        do_cycle($urandom);
        m0_req = 1'b0;
        do_cycle(32'hDEAD_BEEF);

        // Simultaneous requests after reset are granted m0, m1, m0, m1.
        reset_for(1);
        set_m0(1'b1, 1'b0, 32'h0000_0020, 4'hF, 32'd0);
        set_m1(1'b1, 1'b0, 32'h0000_0030, 4'hF, 32'd0);
        for (int i = 0; i < 4; i++) do_cycle($urandom);
        m0_req = 1'b0;
        m1_req = 1'b0;
        do_cycle($urandom);

        // Write path on master 1.
        set_m1(1'b1, 1'b1, 32'h0000_0104, 4'b0011, 32'h1234_5678);
        do_cycle($urandom);
        m1_req = 1'b0;
        do_cycle($urandom);

        // Stall while mem_ready is low for three cycles.
`ifdef DMEM_ARB_PERF_EN
        perf_clr = 1'b1;
        do_cycle($urandom);
        perf_clr = 1'b0;
`endif
        mem_ready = 1'b0;
        set_m0(1'b1, 1'b0, 32'h0000_0200, 4'hF, 32'd0);
        for (int i = 0; i < 3; i++) do_cycle($urandom);
        mem_ready = 1'b1;
        do_cycle($urandom);
        m0_req = 1'b0;
        do_cycle($urandom);
`ifdef DMEM_ARB_PERF_EN
        chk("stall0_is_3", perf_m0_stall, 32'd3);
        perf_clr = 1'b1;
        do_cycle($urandom);
        perf_clr = 1'b0;
        do_cycle($urandom);
        chk("stall0_cleared", perf_m0_stall, 32'd0);
`endif

        // Reset in the cycle after a grant drops the pending response.
        set_m0(1'b1, 1'b0, 32'h0000_0300, 4'hF, 32'd0);
        do_cycle($urandom);
        reset_for(2);
        set_m0(1'b1, 1'b0, 32'h0000_0400, 4'hF, 32'd0);
        set_m1(1'b1, 1'b0, 32'h0000_0500, 4'hF, 32'd0);
        do_cycle($urandom);
        m0_req = 1'b0;
        m1_req = 1'b0;
        do_cycle($urandom);

        // Back-to-back accesses from master 0 only.
        for (int i = 0; i < 4; i++) begin
            set_m0(1'b1, 1'b0, $urandom, 4'hF, 32'd0);
            do_cycle($urandom);
        end
        m0_req = 1'b0;
        do_cycle($urandom);

        // Random traffic. A request that is not granted is held, apart from an occasional withdrawal.
        for (int i = 0; i < 400; i++) begin
            if (m0_req && !(last_acc && last_win == 0)) begin
                if ($urandom_range(0, 19) == 0) m0_req = 1'b0;
            end else if ($urandom_range(0, 9) < 6) begin
                set_m0(1'b1, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom);
            end else begin
                m0_req = 1'b0;
            end
            if (m1_req && !(last_acc && last_win == 1)) begin
                if ($urandom_range(0, 19) == 0) m1_req = 1'b0;
            end else if ($urandom_range(0, 9) < 6) begin
                set_m1(1'b1, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom);
            end else begin
                m1_req = 1'b0;
            end
            mem_ready = ($urandom_range(0, 9) < 8);
`ifdef DMEM_ARB_PERF_EN
            perf_clr = ($urandom_range(0, 49) == 0);
`endif
            do_cycle($urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
